// File: rtl/sh7604_bsc_ext_if.sv
// Bus bundle between the SH7604 DMAC/CPU data bus (DBUS) and the external
// 16-bit memory bus, as seen by the external bus state controller.
//   slave  : the bus state controller (takes DBUS requests, drives MEM_*)
//   master : the DMAC side plus the external memory (drives DBUS_*, MEM_DI,
//            MEM_WAIT_N)
// Signals:
//   DBUS_A/DI/BA/WE/REQ/BURST/LOCK  access request and qualifiers
//   DBUS_DO, DBUS_WAIT, BSC_ACK      read data, completion and ack back
//   MEM_A/DO/CS_N/RD_N/WE_N          external address, data and strobes
//   MEM_DI, MEM_WAIT_N               external read data and wait request
interface sh7604_bsc_ext_if #(
  parameter int AREA_BITS = 2
);
  logic [31:0]                 DBUS_A;
  logic [31:0]                 DBUS_DI;
  logic [31:0]                 DBUS_DO;
  logic [3:0]                  DBUS_BA;
  logic                        DBUS_WE;
  logic                        DBUS_REQ;
  logic                        DBUS_BURST;
  logic                        DBUS_LOCK;
  logic                        DBUS_WAIT;
  logic                        BSC_ACK;
  logic [26:0]                 MEM_A;
  logic [15:0]                 MEM_DO;
  logic [15:0]                 MEM_DI;
  logic [(1<<AREA_BITS)-1:0]   MEM_CS_N;
  logic                        MEM_RD_N;
  logic [1:0]                  MEM_WE_N;
  logic                        MEM_WAIT_N;

  modport slave (
    input  DBUS_A, DBUS_DI, DBUS_BA, DBUS_WE, DBUS_REQ, DBUS_BURST, DBUS_LOCK,
    input  MEM_DI, MEM_WAIT_N,
    output DBUS_DO, DBUS_WAIT, BSC_ACK,
    output MEM_A, MEM_DO, MEM_CS_N, MEM_RD_N, MEM_WE_N
  );

  modport master (
    output DBUS_A, DBUS_DI, DBUS_BA, DBUS_WE, DBUS_REQ, DBUS_BURST, DBUS_LOCK,
    output MEM_DI, MEM_WAIT_N,
    input  DBUS_DO, DBUS_WAIT, BSC_ACK,
    input  MEM_A, MEM_DO, MEM_CS_N, MEM_RD_N, MEM_WE_N
  );
endinterface

// File: rtl/sh7604_bsc_ext.sv
// External bus state controller for the SH7604 data bus.
// Accepts one DBUS access at a time, splits longwords into two 16-bit
// external cycles (high half at A, low half at A+2), inserts programmable
// wait states per chip-select area and stretches on MEM_WAIT_N.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   CE            clock enable for every register and the FSM
//   CFG_WAIT      2-bit wait count per area (area n at [2n+1:2n])
//   bus (slave)   DBUS request/response and external memory bus
module sh7604_bsc_ext #(
  parameter int AREA_BITS = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          CE,
  input  logic [2*(1<<AREA_BITS)-1:0]   CFG_WAIT,
  sh7604_bsc_ext_if.slave               bus
);
  localparam int NUM_AREAS = 1 << AREA_BITS;

  typedef enum logic [2:0] {IDLE, T1, TW, T2, DONE} state_t;

  state_t                 state, state_nx;
  logic [1:0]             wait_cnt;
  logic [AREA_BITS-1:0]   area, prev_area, area_in;
  logic                   we, is_long, half, lock, prev_burst, lock_hold;
  logic [1:0]             lanes;
  logic [15:0]            wdata_lo, rd_hi;
  logic [26:0]            mem_a;
  logic [15:0]            mem_do;
  logic [31:0]            dbus_do;
  logic                   req_long, page_skip, active, cs_on;
  logic [1:0]             cnt_dec;
  logic [NUM_AREAS-1:0]   cs_vec;
  logic                   unused_addr;

  function automatic logic [1:0] area_wait(input logic [2*NUM_AREAS-1:0] cfg,
                                           input logic [AREA_BITS-1:0] ar);
    return cfg[2*ar +: 2];
  endfunction

  assign area_in     = bus.DBUS_A[26 -: AREA_BITS];
  assign req_long    = (bus.DBUS_BA == 4'hF);
  // Consecutive burst accesses to the same area stay on the open page, so
  // the address setup cycle is skipped for the first half.
  assign page_skip   = prev_burst & bus.DBUS_BURST & (area_in == prev_area);
  // Saturating decrement: TW holds at zero while the device stretches.
  assign cnt_dec     = (wait_cnt == 2'd0) ? 2'd0 : wait_cnt - 2'd1;
  assign unused_addr = ^{bus.DBUS_A[31:27], bus.DBUS_A[0]};

  always_ff @(posedge CLK) begin
    if (RST)     state <= IDLE;
    else if (CE) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.DBUS_REQ) begin
          if (page_skip)
            state_nx = ((area_wait(CFG_WAIT, area_in) != 2'd0) || !bus.MEM_WAIT_N) ? TW : T2;
          else
            state_nx = T1;
        end
      end
      T1:      state_nx = ((area_wait(CFG_WAIT, area) != 2'd0) || !bus.MEM_WAIT_N) ? TW : T2;
      TW:      if ((cnt_dec == 2'd0) && bus.MEM_WAIT_N) state_nx = T2;
      T2:      state_nx = (is_long && !half) ? T1 : DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt   <= 2'd0;
      area       <= '0;
      prev_area  <= '0;
      we         <= 1'b0;
      is_long    <= 1'b0;
      half       <= 1'b0;
      lock       <= 1'b0;
      prev_burst <= 1'b0;
      lock_hold  <= 1'b0;
      lanes      <= 2'b00;
      wdata_lo   <= '0;
      rd_hi      <= '0;
      mem_a      <= '0;
      mem_do     <= '0;
      dbus_do    <= '0;
    end else if (CE) begin
      case (state)
        IDLE: begin
          lock_hold <= 1'b0;
          if (bus.DBUS_REQ) begin
            area       <= area_in;
            prev_area  <= area_in;
            prev_burst <= bus.DBUS_BURST;
            we         <= bus.DBUS_WE;
            is_long    <= req_long;
            lock       <= bus.DBUS_LOCK;
            half       <= 1'b0;
            wdata_lo   <= bus.DBUS_DI[15:0];
            wait_cnt   <= area_wait(CFG_WAIT, area_in);
            // Longwords start on the high half; word/byte pick the half by A[1].
            mem_a      <= {bus.DBUS_A[26:2], (req_long ? 1'b0 : bus.DBUS_A[1]), 1'b0};
            mem_do     <= (req_long || !bus.DBUS_A[1]) ? bus.DBUS_DI[31:16] : bus.DBUS_DI[15:0];
            // Bus D[15:8] carries the even byte of the selected half.
            lanes      <= req_long ? 2'b11 : (bus.DBUS_A[1] ? bus.DBUS_BA[1:0] : bus.DBUS_BA[3:2]);
          end
        end
        T1: wait_cnt <= area_wait(CFG_WAIT, area);
        TW: wait_cnt <= cnt_dec;
        T2: begin
          if (is_long && !half) begin
            half     <= 1'b1;
            mem_a[1] <= 1'b1;
            mem_do   <= wdata_lo;
            if (!we) rd_hi <= bus.MEM_DI;
          end else if (!we) begin
            dbus_do <= is_long ? {rd_hi, bus.MEM_DI} : {bus.MEM_DI, bus.MEM_DI};
          end
        end
        DONE: lock_hold <= lock;
        default: ;
      endcase
    end
  end

  assign active = (state == T1) || (state == TW) || (state == T2);

  // A locked sequence keeps its chip select asserted across DONE/IDLE as
  // long as the requester keeps DBUS_REQ up.
  always_comb begin
    cs_on = active ||
            (bus.DBUS_REQ && (((state == DONE) && lock) || ((state == IDLE) && lock_hold)));
    cs_vec       = '0;
    cs_vec[area] = cs_on;
  end

  assign bus.MEM_CS_N  = ~cs_vec;
  assign bus.MEM_RD_N  = ~(active && !we);
  assign bus.MEM_WE_N  = (((state == TW) || (state == T2)) && we) ? ~lanes : 2'b11;
  assign bus.MEM_A     = mem_a;
  assign bus.MEM_DO    = mem_do;
  assign bus.DBUS_DO   = dbus_do;
  assign bus.BSC_ACK   = active;
  assign bus.DBUS_WAIT = bus.DBUS_REQ && (state != DONE);
endmodule

// File: tb/tb_sh7604_bsc_ext.sv
// Testbench for sh7604_bsc_ext: directed accesses, expected responses queued
// at issue time and checked by a monitor thread on every DONE.
module tb_sh7604_bsc_ext;
  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [7:0] cfg;

  sh7604_bsc_ext_if bus ();

  sh7604_bsc_ext dut (
    .CLK      (clk),
    .RST      (rst),
    .CE       (ce),
    .CFG_WAIT (cfg),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int ce_cnt = 0;
  always @(posedge clk) if (ce) ce_cnt <= ce_cnt + 1;

  logic [15:0] rdmem [16];
  assign bus.MEM_DI = rdmem[bus.MEM_A[4:1]];

  typedef struct {
    int          start;
    int          lat;
    logic        rd;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t        sbq [$];
  int          tests = 0;
  int          fails = 0;
  int          done_total = 0;
  int          ack_total = 0, rd_total = 0, we_total = 0, cs1_high = 0;
  logic [26:0] first_a = '0, last_a = '0;
  logic [3:0]  cs_seen = 4'hF;
  logic [1:0]  we_seen = 2'b11;
  logic [15:0] do_seen = '0;
  bit          cs_watch = 0;
  bit          ce_div = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input string name, input logic rd, input logic [31:0] data, input int lat);
    exp_t e;
    e.start = ce_cnt; e.lat = lat; e.rd = rd; e.data = data; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] di, input logic [3:0] ba,
                       input logic we, input logic burst, input logic lock);
    bus.DBUS_A = a; bus.DBUS_DI = di; bus.DBUS_BA = ba;
    bus.DBUS_WE = we; bus.DBUS_BURST = burst; bus.DBUS_LOCK = lock;
    bus.DBUS_REQ = 1'b1;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_total < target && n < budget) begin
      tick();
      n++;
    end
    if (done_total < target) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: done count %0d, required %0d", name, done_total, target);
    end
  endtask

  // Pops one expectation per DONE (rising edge of REQ & ~WAIT).
  task automatic scoreboard();
    bit   done_prev = 0;
    bit   done_now;
    exp_t e;
    forever begin
      @(negedge clk);
      done_now = bus.DBUS_REQ && !bus.DBUS_WAIT;
      if (done_now && !done_prev) begin
        done_total++;
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: DONE seen at ce cycle %0d, required none", ce_cnt);
        end else begin
          e = sbq.pop_front();
          check({e.name, "_latency"}, ce_cnt - e.start, e.lat);
          if (e.rd) check({e.name, "_rdata"}, bus.DBUS_DO, e.data);
        end
      end
      done_prev = done_now;
    end
  endtask

  task automatic bus_mon();
    bit ack_prev = 0;
    forever begin
      @(negedge clk);
      if (bus.BSC_ACK) begin
        ack_total++;
        last_a  = bus.MEM_A;
        cs_seen = bus.MEM_CS_N;
        if (!ack_prev) first_a = bus.MEM_A;
        if (!bus.MEM_RD_N) rd_total++;
        if (bus.MEM_WE_N != 2'b11) begin
          we_total++;
          we_seen = bus.MEM_WE_N;
          do_seen = bus.MEM_DO;
        end
      end
      ack_prev = bus.BSC_ACK;
      if (cs_watch && bus.MEM_CS_N[1]) cs1_high++;
    end
  endtask

  task automatic ce_driver();
    int ph = 0;
    forever begin
      @(negedge clk);
      #1;
      if (ce_div) begin
        ce = (ph == 0);
        ph = (ph == 2) ? 0 : ph + 1;
      end else begin
        ce = 1'b1;
      end
    end
  endtask

  initial begin
    int d0, k, n, a0, r0, w0, c0;
    logic [15:0] hi;
    rst = 1'b1; ce = 1'b1; cfg = 8'h00;
    bus.DBUS_A = '0; bus.DBUS_DI = '0; bus.DBUS_BA = 4'h0; bus.DBUS_WE = 1'b0;
    bus.DBUS_REQ = 1'b0; bus.DBUS_BURST = 1'b0; bus.DBUS_LOCK = 1'b0;
    bus.MEM_WAIT_N = 1'b1;
    for (int i = 0; i < 16; i++) rdmem[i] = 16'hA0A0 + 16'(i);
    rdmem[8] = 16'h1234; rdmem[9] = 16'h5678; rdmem[11] = 16'hBEEF;
    fork
      scoreboard();
      bus_mon();
      ce_driver();
    join_none

    // Reset state
    repeat (3) tick();
    check("rst_cs_n",    bus.MEM_CS_N, 4'hF);
    check("rst_rd_n",    bus.MEM_RD_N, 1'b1);
    check("rst_we_n",    bus.MEM_WE_N, 2'b11);
    check("rst_mem_a",   bus.MEM_A, 27'h0);
    check("rst_mem_do",  bus.MEM_DO, 16'h0);
    check("rst_dbus_do", bus.DBUS_DO, 32'h0);
    check("rst_ack",     bus.BSC_ACK, 1'b0);
    check("rst_wait_lo", bus.DBUS_WAIT, 1'b0);
    bus.DBUS_REQ = 1'b1;
    #1;
    check("rst_wait_hi", bus.DBUS_WAIT, 1'b1);
    bus.DBUS_REQ = 1'b0;
    rst = 1'b0;
    tick();

    // Longword read, area 0, no waits: two T1/T2 pairs, done at cycle 5
    cfg = 8'h00;
    d0 = done_total; a0 = ack_total; r0 = rd_total;
    drive(32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    push_exp("lread", 1'b1, 32'h1234_5678, 5);
    wait_done(d0 + 1, 20, "lread");
    bus.DBUS_REQ = 1'b0;
    check("lread_first_a", first_a, 27'h10);
    check("lread_last_a",  last_a, 27'h12);
    check("lread_acks",    ack_total - a0, 4);
    check("lread_rd_low",  rd_total - r0, 4);
    check("lread_cs",      cs_seen, 4'hE);
    tick();

    // Byte write at A=3, one wait state: done at cycle 4
    cfg = 8'h01;
    d0 = done_total; r0 = rd_total; w0 = we_total;
    drive(32'h0000_0003, 32'h0000_00AB, 4'b0001, 1'b1, 1'b0, 1'b0);
    push_exp("bwrite", 1'b0, 32'h0, 4);
    wait_done(d0 + 1, 20, "bwrite");
    bus.DBUS_REQ = 1'b0;
    check("bwrite_we_n",    we_seen, 2'b10);
    check("bwrite_mem_do",  do_seen, 16'h00AB);
    check("bwrite_mem_a",   first_a, 27'h2);
    check("bwrite_we_low",  we_total - w0, 2);
    check("bwrite_no_rd",   rd_total - r0, 0);
    check("bwrite_do_held", bus.DBUS_DO, 32'h1234_5678);
    tick();

    // Word read, area 2, 2 waits plus 3 MEM_WAIT_N stretch cycles: done at 8
    cfg = 8'h20;
    d0 = done_total; a0 = ack_total;
    bus.MEM_WAIT_N = 1'b0;
    drive(32'h0400_0016, 32'h0, 4'b1100, 1'b0, 1'b0, 1'b0);
    push_exp("wread", 1'b1, 32'hBEEF_BEEF, 8);
    k = ce_cnt; n = 0;
    while (ce_cnt < k + 6 && n < 20) begin tick(); n++; end
    bus.MEM_WAIT_N = 1'b1;
    wait_done(d0 + 1, 20, "wread");
    bus.DBUS_REQ = 1'b0;
    check("wread_cs",   cs_seen, 4'hB);
    check("wread_acks", ack_total - a0, 7);
    tick();

    // Locked 4-longword burst, area 1: later beats skip T1, CS[1] stays low
    cfg = 8'h00;
    d0 = done_total; a0 = ack_total; c0 = cs1_high;
    drive(32'h0200_0020, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1);
    push_exp("burst0", 1'b1, 32'hA0A0_A0A1, 5);
    n = 0;
    while (!bus.BSC_ACK && n < 10) begin tick(); n++; end
    cs_watch = 1;
    for (int i = 1; i < 4; i++) begin
      wait_done(d0 + i, 20, "burst");
      bus.DBUS_A = 32'h0200_0020 + 32'(4 * i);
      hi = 16'hA0A0 + 16'(2 * i);
      // Measured from the DONE of the previous beat: 1 cycle back to IDLE + 4.
      push_exp("burst", 1'b1, {hi, hi + 16'h1}, 5);
    end
    wait_done(d0 + 4, 20, "burst3");
    cs_watch = 0;
    check("burst_cs1_held", cs1_high - c0, 0);
    check("burst_acks",     ack_total - a0, 13);
    check("burst_cs_locked_done", bus.MEM_CS_N, 4'hD);
    bus.DBUS_REQ = 1'b0;
    #1;
    check("burst_cs_release", bus.MEM_CS_N, 4'hF);
    tick();

    // Reset in TW of a longword write: abort, no DONE, history cleared
    cfg = 8'h08;
    d0 = done_total;
    drive(32'h0200_0040, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b1, 1'b0);
    k = ce_cnt; n = 0;
    while (ce_cnt < k + 2 && n < 10) begin tick(); n++; end
    check("abort_in_tw_we", bus.MEM_WE_N, 2'b00);
    rst = 1'b1;
    tick();
    check("abort_we_n", bus.MEM_WE_N, 2'b11);
    check("abort_rd_n", bus.MEM_RD_N, 1'b1);
    check("abort_cs_n", bus.MEM_CS_N, 4'hF);
    check("abort_ack",  bus.BSC_ACK, 1'b0);
    check("abort_wait", bus.DBUS_WAIT, 1'b1);
    rst = 1'b0;
    bus.DBUS_REQ = 1'b0;
    repeat (3) tick();
    check("abort_no_done", done_total - d0, 0);
    cfg = 8'h00;
    d0 = done_total;
    drive(32'h0200_0020, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
    push_exp("post_rst", 1'b1, 32'hA0A0_A0A1, 5);
    wait_done(d0 + 1, 20, "post_rst");
    bus.DBUS_REQ = 1'b0;
    tick();

    // Word read with CE active one cycle in three: same CE-cycle latency
    cfg = 8'h01;
    ce_div = 1;
    tick();
    d0 = done_total;
    drive(32'h0000_0012, 32'h0, 4'b0011, 1'b0, 1'b0, 1'b0);
    push_exp("ce_wread", 1'b1, 32'h5678_5678, 4);
    wait_done(d0 + 1, 40, "ce_wread");
    bus.DBUS_REQ = 1'b0;
    check("ce_wread_mem_a", first_a, 27'h12);
    ce_div = 0;
    repeat (3) tick();

    check("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
